// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares a single-port word data memory between the CPU (port 0)
// and the debug/DMA loader (port 1); partial stores become read-modify-write.
module dm_port_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic [3:0]        req0_be,
    output logic              resp0_valid,
    output logic [31:0]       resp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    input  logic [3:0]        req1_be,
    output logic              resp1_valid,
    output logic [31:0]       resp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       old_q, old_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [31:0]       resp0_rdata_q, resp0_rdata_d;
    logic [31:0]       resp1_rdata_q, resp1_rdata_d;

    logic              grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       resp_data;
    logic              resp_fire;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Only a contested cycle consults the priority rule; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = FIXED_PRIO ? 1'b0 : rr_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign sel_addr   = grant ? req1_addr : req0_addr;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        old_d         = old_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp0_rdata_d = resp0_rdata_q;
        resp1_rdata_d = resp1_rdata_q;
        resp_fire     = 1'b0;
        resp_data     = old_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d    = grant;
                    rr_d       = ~grant;
                    wr_d       = grant ? req1_write : req0_write;
                    wdata_d    = grant ? req1_wdata : req0_wdata;
                    be_d       = grant ? req1_be    : req0_be;
                    mem_addr_d = sel_addr & WORD_MASK;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                old_d = mem_rdata;
                if (wr_q && (be_q != 4'b0000)) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_bytes(mem_rdata, wdata_q, be_q);
                    state_d     = S_WRITE;
                end else begin
                    resp_fire = 1'b1;
                    resp_data = mem_rdata;
                    state_d   = S_RESP;
                end
            end
            S_WRITE: begin
                resp_fire = 1'b1;
                resp_data = old_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response outputs are registered, so they are loaded on the edge entering RESP.
        if (resp_fire) begin
            if (owner_q) begin
                resp1_valid_d = 1'b1;
                resp1_rdata_d = resp_data;
            end else begin
                resp0_valid_d = 1'b1;
                resp0_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rr_q          <= 1'b0;
            owner_q       <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            be_q          <= '0;
            old_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            old_q         <= old_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_rdata = resp0_rdata_q;
    assign resp1_rdata = resp1_rdata_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each with its own word memory and a reference memory image kept by the bench.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rq_valid [2][2];
    logic        rq_write [2][2];
    logic [31:0] rq_addr  [2][2];
    logic [31:0] rq_wdata [2][2];
    logic [3:0]  rq_be    [2][2];
    logic        rq_ready [2][2];
    logic        rs_valid [2][2];
    logic [31:0] rs_rdata [2][2];
    logic        mem_we   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];
    logic        busy     [2];

    logic [31:0] mem     [2][64];
    logic [31:0] ref_mem [2][64];
    bit          ref_rr  [2];
    logic        poke_en [2];
    logic [5:0]  poke_w  [2];
    logic [31:0] poke_v  [2];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_port_arbiter #(.FIXED_PRIO(g == 1), .ADDR_W(32)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req0_valid (rq_valid[g][0]),
            .req0_ready (rq_ready[g][0]),
            .req0_write (rq_write[g][0]),
            .req0_addr  (rq_addr[g][0]),
            .req0_wdata (rq_wdata[g][0]),
            .req0_be    (rq_be[g][0]),
            .resp0_valid(rs_valid[g][0]),
            .resp0_rdata(rs_rdata[g][0]),
            .req1_valid (rq_valid[g][1]),
            .req1_ready (rq_ready[g][1]),
            .req1_write (rq_write[g][1]),
            .req1_addr  (rq_addr[g][1]),
            .req1_wdata (rq_wdata[g][1]),
            .req1_be    (rq_be[g][1]),
            .resp1_valid(rs_valid[g][1]),
            .resp1_rdata(rs_rdata[g][1]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g]),
            .busy       (busy[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g][7:2]];
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_we[g]) mem[g][mem_addr[g][7:2]] <= mem_wdata[g];
            else if (poke_en[g]) mem[g][poke_w[g]] <= poke_v[g];
        end
    end

    task automatic poke(input int d, input int w, input logic [31:0] v);
        poke_en[d] = 1'b1;
        poke_w[d]  = w[5:0];
        poke_v[d]  = v;
        @(posedge clk); #1;
        poke_en[d] = 1'b0;
        ref_mem[d][w] = v;
    endtask

    task automatic txn(input int d, input int p, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input string name);
        int w, exp_lat, lat, we_cnt, rsp_cnt, oth_cnt;
        logic [31:0] old_w, new_w, got;
        bit seen;
        w = int'(addr[7:2]);
        old_w = ref_mem[d][w];
        new_w = old_w;
        if (wr) for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
        exp_lat = (wr && be != 4'b0000) ? 3 : 2;
        rq_valid[d][p] = 1'b1; rq_write[d][p] = wr; rq_addr[d][p] = addr;
        rq_wdata[d][p] = wd;   rq_be[d][p] = be;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rq_ready[d][p];
        end
        n_run++;
        if (!seen) begin n_fail++; $display("FAIL %s accept: ready got 0 required 1", name); end
        @(posedge clk); #1;
        rq_valid[d][p] = 1'b0;
        lat = 0; we_cnt = 0; rsp_cnt = 0; oth_cnt = 0; got = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_run++;
                if (busy[d] !== 1'b1 || mem_addr[d] !== {addr[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL %s read_phase: busy=%b addr=%h required busy=1 addr=%h",
                             name, busy[d], mem_addr[d], {addr[31:2], 2'b00});
                end
            end
            if (mem_we[d] === 1'b1) begin
                we_cnt++;
                n_run++;
                if (mem_wdata[d] !== new_w) begin
                    n_fail++;
                    $display("FAIL %s mem_wdata: got %h required %h", name, mem_wdata[d], new_w);
                end
            end
            if (rs_valid[d][p] === 1'b1) begin rsp_cnt++; lat = c; got = rs_rdata[d][p]; end
            if (rs_valid[d][1-p] === 1'b1) oth_cnt++;
        end
        n_run++;
        if (rsp_cnt != 1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s resp_latency: got %0d pulses at cycle %0d required 1 at %0d",
                     name, rsp_cnt, lat, exp_lat);
        end
        n_run++;
        if (got !== old_w) begin n_fail++; $display("FAIL %s rdata: got %h required %h", name, got, old_w); end
        n_run++;
        if (we_cnt != ((exp_lat == 3) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s we_pulses: got %0d required %0d", name, we_cnt, (exp_lat == 3) ? 1 : 0);
        end
        n_run++;
        if (oth_cnt != 0) begin n_fail++; $display("FAIL %s other_resp: got %0d required 0", name, oth_cnt); end
        n_run++;
        if (mem[d][w] !== new_w) begin n_fail++; $display("FAIL %s memory: got %h required %h", name, mem[d][w], new_w); end
        n_run++;
        if (rs_rdata[d][p] !== old_w) begin
            n_fail++;
            $display("FAIL %s rdata_hold: got %h required %h", name, rs_rdata[d][p], old_w);
        end
        ref_mem[d][w] = new_w;
        ref_rr[d] = (p == 0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_run++;
            if (mem_we[d] !== 1'b0 || mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0 || busy[d] !== 1'b0 ||
                rs_valid[d][0] !== 1'b0 || rs_valid[d][1] !== 1'b0 || rs_rdata[d][0] !== 32'h0 ||
                rs_rdata[d][1] !== 32'h0 || rq_ready[d][0] !== 1'b0 || rq_ready[d][1] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: we=%b addr=%h busy=%b rv=%b%b required all 0",
                         d, mem_we[d], mem_addr[d], busy[d], rs_valid[d][1], rs_valid[d][0]);
            end
        end
    endtask

    task automatic test_load();
        poke(0, 4, 32'hDEADBEEF);
        txn(0, 0, 1'b0, 32'h10, 32'h0, 4'b0000, "load");
        n_run++;
        if (rs_rdata[0][0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_value: got %h required deadbeef", rs_rdata[0][0]);
        end
    endtask

    task automatic test_store_full();
        txn(0, 1, 1'b1, 32'h20, 32'h12345678, 4'b1111, "store_full");
        n_run++;
        if (mem[0][8] !== 32'h12345678) begin
            n_fail++; $display("FAIL store_full_value: got %h required 12345678", mem[0][8]);
        end
    endtask

    task automatic test_store_partial();
        poke(0, 8, 32'hAABBCCDD);
        txn(0, 0, 1'b1, 32'h22, 32'h11223344, 4'b0101, "store_partial");
        n_run++;
        if (mem[0][8] !== 32'hAA22CC44 || rs_rdata[0][0] !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL store_partial_value: mem %h old %h required aa22cc44 aabbccdd", mem[0][8], rs_rdata[0][0]);
        end
    endtask

    task automatic test_store_no_be();
        txn(0, 1, 1'b1, 32'h24, 32'hFFFFFFFF, 4'b0000, "store_be0");
    endtask

    task automatic test_arbitration(input int d);
        int grants, last_c, cyc;
        bit g, exp_g;
        grants = 0; last_c = -1; cyc = 0;
        for (int p = 0; p < 2; p++) begin
            rq_write[d][p] = 1'b0; rq_be[d][p] = 4'b0000; rq_wdata[d][p] = '0;
            rq_addr[d][p] = (p == 0) ? 32'h10 : 32'h20;
            rq_valid[d][p] = 1'b1;
        end
        while (grants < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rq_ready[d][0] || rq_ready[d][1]) begin
                g = rq_ready[d][1];
                exp_g = !rq_valid[d][0] ? 1'b1 : ((d == 1) ? 1'b0 : ref_rr[d]);
                n_run++;
                if ((rq_ready[d][0] && rq_ready[d][1]) || g !== exp_g) begin
                    n_fail++;
                    $display("FAIL arb[%0d] grant %0d: got ready=%b%b required port %0d",
                             d, grants, rq_ready[d][1], rq_ready[d][0], exp_g);
                end
                if (last_c >= 0) begin
                    n_run++;
                    if (cyc - last_c != 3) begin
                        n_fail++;
                        $display("FAIL arb[%0d] spacing: got %0d cycles required 3", d, cyc - last_c);
                    end
                end
                last_c = cyc;
                ref_rr[d] = !g;
                grants++;
                if (d == 1 && grants == 4) begin
                    @(posedge clk); #1;
                    rq_valid[d][0] = 1'b0;
                end
            end
        end
        n_run++;
        if (grants != 8) begin n_fail++; $display("FAIL arb[%0d] grant_count: got %0d required 8", d, grants); end
        @(posedge clk); #1;
        rq_valid[d][0] = 1'b0; rq_valid[d][1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int d);
        int p;
        bit wr;
        logic [3:0] be;
        for (int i = 0; i < 24; i++) begin
            p  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            be = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            txn(d, p, wr, 32'($urandom_range(0, 255)), $urandom(), be, "random");
        end
    endtask

    task automatic test_reset_mid_write(input int d);
        bit seen;
        int cnt;
        poke(d, 12, 32'h0BADF00D);
        rq_valid[d][0] = 1'b1; rq_write[d][0] = 1'b1; rq_addr[d][0] = 32'h30;
        rq_wdata[d][0] = 32'h5555AAAA; rq_be[d][0] = 4'b1111;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = rq_ready[d][0]; end
        @(posedge clk); #1;
        rq_valid[d][0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin @(negedge clk); seen = mem_we[d]; end
        n_run++;
        if (!seen) begin n_fail++; $display("FAIL rst_write reach_write: mem_we got 0 required 1"); end
        #1 reset = 1'b0;
        #1;
        n_run++;
        if (mem_we[d] !== 1'b0 || busy[d] !== 1'b0 || rs_valid[d][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_write outputs: we=%b busy=%b rv=%b required 0 0 0", mem_we[d], busy[d], rs_valid[d][0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rs_valid[d][0] || rs_valid[d][1] || mem_we[d]) cnt++;
        end
        n_run++;
        if (cnt != 0 || mem[d][12] !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL rst_write aftermath: activity %0d mem %h required 0 0badf00d", cnt, mem[d][12]);
        end
        ref_rr[0] = 1'b0;
        ref_rr[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            poke_en[d] = 1'b0; poke_w[d] = '0; poke_v[d] = '0; ref_rr[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rq_valid[d][p] = 1'b0; rq_write[d][p] = 1'b0; rq_addr[d][p] = '0;
                rq_wdata[d][p] = '0;   rq_be[d][p] = '0;
            end
        end
        #3;
        test_reset();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) poke(d, w, $urandom());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        test_load();
        test_store_full();
        test_store_partial();
        test_store_no_be();
        test_arbitration(0);
        test_arbitration(1);
        test_random(0);
        test_random(1);
        test_reset_mid_write(0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
